// File: rtl/baud_pkg.sv
// baud_pkg: shared types and constants for the autobaud detector
package baud_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_IDLE, ARMED, MEASURE} state_e;
    localparam int DIV_W_DEF  = 17;
    localparam int CNT_W_DEF  = 20;
    localparam int SYNC_EDGES = 5;
    localparam int ROUND      = 4;
endpackage

// File: rtl/rx_sync_edge.sv
// rx_sync_edge: 2-flop synchronizer plus falling-edge detector for the RX line
//   clk, rst : clock, synchronous active-high reset
//   rx       : asynchronous serial input, idle high
//   rx_s     : synchronized rx
//   fe       : 1-cycle pulse on a synchronized 1->0 transition
module rx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fe
);
    logic [2:0] sync_q;
    always_ff @(posedge clk)
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[1:0], rx};
    assign rx_s = sync_q[1];
    assign fe   = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/baud_rate_detector.sv
// baud_rate_detector: measures the bit period of a 0x55 sync character and outputs the baud divisor
//   clk, rst  : clock, synchronous active-high reset
//   start     : 1-cycle pulse, arms (or restarts) a measurement
//   rx        : asynchronous serial line, idle high
//   busy      : measurement in progress
//   done/err  : 1-cycle result pulses (new divisor / rejected)
//   baudeRate : measured divisor, held between measurements
//   Define AUTOBAUD_CHECK_EN to reject frames whose edge-to-edge intervals deviate by more than 12.5%.
module baud_rate_detector
    import baud_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MIN_DIV     = 4,
    parameter int DEFAULT_DIV = 434
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [DIV_W-1:0] baudeRate
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       edges_q, edges_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic             done_q, done_d, err_q, err_d;
    logic             rx_s, fe, last_fe, cnt_max, fail, ok, check_bad;
    logic [CNT_W:0]   sum;
    logic [DIV_W-1:0] div;

    rx_sync_edge u_sync (.clk(clk), .rst(rst), .rx(rx), .rx_s(rx_s), .fe(fe));

    assign last_fe = state_q == MEASURE && fe && edges_q == 3'(SYNC_EDGES - 1);
    assign cnt_max = &cnt_q;
    assign sum     = {1'b0, cnt_q} + (CNT_W + 1)'(ROUND);
    assign div     = DIV_W'(sum >> 3);
    assign fail    = div < DIV_W'(MIN_DIV) || check_bad;
    assign ok      = last_fe && !fail;

`ifdef AUTOBAUD_CHECK_EN
    // last_q holds the span count at the previous edge, so cnt_q - last_q is the current interval
    logic [CNT_W-1:0] last_q, first_q, ivl, diff;
    logic             bad_q, ivl_bad;
    assign ivl       = cnt_q - last_q;
    assign diff      = ivl > first_q ? ivl - first_q : first_q - ivl;
    assign ivl_bad   = edges_q != 3'd1 && diff > (first_q >> 3);
    assign check_bad = bad_q | ivl_bad;
    always_ff @(posedge clk)
        if (rst) begin
            last_q  <= '0;
            first_q <= '0;
            bad_q   <= 1'b0;
        end else if (fe) begin
            last_q  <= state_q == MEASURE ? cnt_q : '0;
            first_q <= edges_q == 3'd1 ? ivl : first_q;
            bad_q   <= state_q == MEASURE && check_bad;
        end
`else
    assign check_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edges_d = edges_q;
        baud_d  = baud_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (start) begin
            state_d = WAIT_IDLE;
        end else if (state_q == WAIT_IDLE) begin
            state_d = rx_s ? ARMED : WAIT_IDLE;
        end else if (state_q == ARMED && fe) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
            edges_d = 3'd1;
        end else if (state_q == MEASURE) begin
            cnt_d   = cnt_q + 1'b1;
            edges_d = fe ? edges_q + 3'd1 : edges_q;
            if (last_fe || cnt_max) begin
                state_d = IDLE;
                done_d  = ok;
                err_d   = !ok;
                baud_d  = ok ? div : baud_q;
            end
        end
    end

    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edges_q <= '0;
            baud_q  <= DIV_W'(DEFAULT_DIV);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edges_q <= edges_d;
            baud_q  <= baud_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end

    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign err       = err_q;
    assign baudeRate = baud_q;
endmodule

// File: tb/tb_baud_rate_detector.sv
// tb_baud_rate_detector: randomized self-checking bench against a frame-level timing model
module tb_baud_rate_detector;
    localparam int CNT_W = 12;
    localparam logic [9:0] FRAME = {1'b1, 8'h55, 1'b0};

    logic        clk = 1'b0;
    logic        rst, start, rx, busy, done, err;
    logic [16:0] baudeRate;
    int          n_checks = 0, n_fail = 0, n_done = 0, n_err = 0, exp_baud = 434;

    baud_rate_detector #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rx(rx),
        .busy(busy), .done(done), .err(err), .baudeRate(baudeRate)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && (done || err)) begin
            n_done += int'(done);
            n_err  += int'(err);
            check("busy_at_pulse", int'(busy), 0);
            check("done_err_excl", int'(done && err), 0);
        end

    // Expected outcome from the frame's bit durations: edge times, span, rounding and the rejection rules.
    task automatic model(input int bw[10], output bit ok, output int dv);
        logic [9:0] fr = FRAME;
        int e[$];
        int t = 0, span, first, d;
        bit prev = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (prev && !fr[k]) e.push_back(t);
            prev = fr[k];
            t += bw[k];
        end
        span = e[4] - e[0];
        dv   = ((span + 4) / 8) % (1 << 17);
        ok   = span <= (1 << CNT_W) - 1 && dv >= 4;
`ifdef AUTOBAUD_CHECK_EN
        first = e[1] - e[0];
        for (int j = 1; j < 4; j++) begin
            d = (e[j+1] - e[j]) - first;
            if (d < 0) d = -d;
            if (d > first / 8) ok = 1'b0;
        end
`else
        first = 0;
        d = first;
`endif
    endtask

    task automatic pulse_start();
        rx = 1'b1;
        n_done = 0;
        n_err = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input int bw[10], input int nbits);
        logic [9:0] fr = FRAME;
        for (int k = 0; k < nbits; k++) begin
            rx = fr[k];
            repeat (bw[k]) @(posedge clk);
            #1;
        end
    endtask

    task automatic measure(input string tag, input int bw[10]);
        bit ok;
        int dv;
        model(bw, ok, dv);
        pulse_start();
        drive_bits(bw, 10);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check({tag, "_done"}, n_done, int'(ok));
        check({tag, "_err"}, n_err, int'(!ok));
        if (ok) exp_baud = dv;
        check({tag, "_baud"}, int'(baudeRate), exp_baud);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic measure_p(input string tag, input int p);
        int bw[10];
        foreach (bw[k]) bw[k] = p;
        measure(tag, bw);
    endtask

    initial begin
        int bw[10];
        int p;
        rst = 1'b1; start = 1'b0; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_baud", int'(baudeRate), 434);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        measure_p("p10", 10);
        check("p10_value", int'(baudeRate), 10);
        measure_p("p217", 217);
        measure_p("p87", 87);
        check("p87_value", int'(baudeRate), 87);
        // line stuck low after the start edge
        pulse_start();
        rx = 1'b0;
        repeat (4300) @(posedge clk);
        @(negedge clk);
        check("stuck_err", n_err, 1);
        check("stuck_done", n_done, 0);
        check("stuck_baud", int'(baudeRate), exp_baud);
        check("stuck_busy", int'(busy), 0);
        measure_p("p3", 3);
        measure_p("p4", 4);
        // abort mid-frame, then a fresh frame
        foreach (bw[k]) bw[k] = 30;
        pulse_start();
        drive_bits(bw, 5);
        @(negedge clk);
        check("abort_pulses", n_done + n_err, 0);
        check("abort_busy", int'(busy), 1);
        measure_p("p20", 20);
        check("p20_value", int'(baudeRate), 20);
        // start arriving together with the 5th falling edge
        foreach (bw[k]) bw[k] = 12;
        pulse_start();
        drive_bits(bw, 8);
        rx = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 rx = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("collide_pulses", n_done + n_err, 0);
        check("collide_baud", int'(baudeRate), exp_baud);
        check("collide_busy", int'(busy), 1);
        // b4 stretched to 26 clocks
        foreach (bw[k]) bw[k] = 20;
        bw[5] = 26;
        measure("stretch", bw);
`ifdef AUTOBAUD_CHECK_EN
        check("stretch_rule", n_err, 1);
`else
        check("stretch_rule", int'(baudeRate), 21);
`endif
        for (int i = 0; i < 8; i++) begin
            p = int'($urandom_range(3, 200));
            foreach (bw[k]) bw[k] = p + int'($urandom_range(0, p / 4)) - p / 8;
            measure($sformatf("rnd%0d", i), bw);
        end
        // reset in the middle of a measurement
        foreach (bw[k]) bw[k] = 15;
        pulse_start();
        drive_bits(bw, 4);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_baud", int'(baudeRate), 434);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_pulses", n_done + n_err, 0);
        exp_baud = 434;
        measure_p("post_rst", 50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
